// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - load-use hazard detector with a multi-cycle load scoreboard and a mem_wait freeze path.
// Optional perf counters (perf_stalls, perf_freezes) are built when LOAD_USE_PERF_EN is defined.
module load_use_scoreboard #(
    parameter int REG_W           = 5,
    parameter int LOAD_LAT        = 1,
    parameter int ZERO_REG_EXEMPT = 1,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EXMemRead,
    input  logic [REG_W-1:0] ID_EXRt,
    input  logic [REG_W-1:0] IF_IDRs,
    input  logic [REG_W-1:0] IF_IDRt,
    input  logic             IF_IDuseRs,
    input  logic             IF_IDuseRt,
    input  logic             mem_wait,
    output logic             ID_EXzero,
    output logic             IF_IDhold,
    output logic             sel,
    output logic             pipe_freeze,
`ifdef LOAD_USE_PERF_EN
    output logic [31:0]      perf_stalls,
    output logic [31:0]      perf_freezes,
`endif
    output logic [CNT_W-1:0] stall_run
);

    localparam int SB_DEPTH = LOAD_LAT - 1;

    logic sb_hit_rs;
    logic sb_hit_rt;
    logic hazard;

    function automatic logic exempt(input logic [REG_W-1:0] r);
        return (ZERO_REG_EXEMPT != 0) && (r == '0);
    endfunction

    // Loads that have left ID/EX but whose data is not yet forwardable.
    generate
        if (SB_DEPTH > 0) begin : g_sb
            logic [SB_DEPTH-1:0]            sb_valid;
            logic [SB_DEPTH-1:0][REG_W-1:0] sb_dest;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sb_valid <= '0;
                    sb_dest  <= '0;
                end else if (!mem_wait) begin
                    sb_valid[0] <= ID_EXMemRead;
                    sb_dest[0]  <= ID_EXRt;
                    for (int k = 1; k < SB_DEPTH; k++) begin
                        sb_valid[k] <= sb_valid[k-1];
                        sb_dest[k]  <= sb_dest[k-1];
                    end
                end
            end

            always_comb begin
                sb_hit_rs = 1'b0;
                sb_hit_rt = 1'b0;
                for (int k = 0; k < SB_DEPTH; k++) begin
                    if (sb_valid[k] && (sb_dest[k] == IF_IDRs)) sb_hit_rs = 1'b1;
                    if (sb_valid[k] && (sb_dest[k] == IF_IDRt)) sb_hit_rt = 1'b1;
                end
            end
        end else begin : g_no_sb
            assign sb_hit_rs = 1'b0;
            assign sb_hit_rt = 1'b0;
        end
    endgenerate

    always_comb begin
        logic match_rs;
        logic match_rt;
        match_rs = ((ID_EXMemRead && (ID_EXRt == IF_IDRs)) || sb_hit_rs) && !exempt(IF_IDRs);
        match_rt = ((ID_EXMemRead && (ID_EXRt == IF_IDRt)) || sb_hit_rt) && !exempt(IF_IDRt);
        hazard   = (IF_IDuseRs && match_rs) || (IF_IDuseRt && match_rt);
    end

    // mem_wait freezes everything without a bubble; the hazard is rechecked once it drops.
    always_comb begin
        ID_EXzero   = 1'b0;
        IF_IDhold   = 1'b0;
        sel         = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                pipe_freeze = 1'b1;
                IF_IDhold   = 1'b1;
                sel         = 1'b1;
            end else if (hazard) begin
                ID_EXzero = 1'b1;
                IF_IDhold = 1'b1;
                sel       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run <= '0;
        end else if (!mem_wait) begin
            if (!hazard) begin
                stall_run <= '0;
            end else if (stall_run != '1) begin
                stall_run <= stall_run + 1'b1;
            end
        end
    end

`ifdef LOAD_USE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stalls  <= '0;
            perf_freezes <= '0;
        end else begin
            if (mem_wait) perf_freezes <= perf_freezes + 32'd1;
            else if (hazard) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb/tb_load_use_scoreboard.sv - directed bench for load_use_scoreboard across several latency/exemption builds.
module tb_load_use_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       mr, mw, urs, urt;
    logic [4:0] ert, rs, rt;

    // 0: LAT1 exempt, 1: LAT1 no exempt CNT_W=2, 2: LAT2, 3: LAT3
    logic [3:0] zx, hx, sx, fx;
    logic [7:0] sr0, sr2, sr3;
    logic [1:0] srz;
`ifdef LOAD_USE_PERF_EN
    logic [31:0] ps [4];
    logic [31:0] pf [4];
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_use_scoreboard #(.REG_W(5), .LOAD_LAT(1), .ZERO_REG_EXEMPT(1), .CNT_W(8)) u_d0 (
        .clk(clk), .rst(rst), .ID_EXMemRead(mr), .ID_EXRt(ert), .IF_IDRs(rs), .IF_IDRt(rt),
        .IF_IDuseRs(urs), .IF_IDuseRt(urt), .mem_wait(mw),
        .ID_EXzero(zx[0]), .IF_IDhold(hx[0]), .sel(sx[0]), .pipe_freeze(fx[0]),
`ifdef LOAD_USE_PERF_EN
        .perf_stalls(ps[0]), .perf_freezes(pf[0]),
`endif
        .stall_run(sr0));

    load_use_scoreboard #(.REG_W(5), .LOAD_LAT(1), .ZERO_REG_EXEMPT(0), .CNT_W(2)) u_d1 (
        .clk(clk), .rst(rst), .ID_EXMemRead(mr), .ID_EXRt(ert), .IF_IDRs(rs), .IF_IDRt(rt),
        .IF_IDuseRs(urs), .IF_IDuseRt(urt), .mem_wait(mw),
        .ID_EXzero(zx[1]), .IF_IDhold(hx[1]), .sel(sx[1]), .pipe_freeze(fx[1]),
`ifdef LOAD_USE_PERF_EN
        .perf_stalls(ps[1]), .perf_freezes(pf[1]),
`endif
        .stall_run(srz));

    load_use_scoreboard #(.REG_W(5), .LOAD_LAT(2), .ZERO_REG_EXEMPT(1), .CNT_W(8)) u_d2 (
        .clk(clk), .rst(rst), .ID_EXMemRead(mr), .ID_EXRt(ert), .IF_IDRs(rs), .IF_IDRt(rt),
        .IF_IDuseRs(urs), .IF_IDuseRt(urt), .mem_wait(mw),
        .ID_EXzero(zx[2]), .IF_IDhold(hx[2]), .sel(sx[2]), .pipe_freeze(fx[2]),
`ifdef LOAD_USE_PERF_EN
        .perf_stalls(ps[2]), .perf_freezes(pf[2]),
`endif
        .stall_run(sr2));

    load_use_scoreboard #(.REG_W(5), .LOAD_LAT(3), .ZERO_REG_EXEMPT(1), .CNT_W(8)) u_d3 (
        .clk(clk), .rst(rst), .ID_EXMemRead(mr), .ID_EXRt(ert), .IF_IDRs(rs), .IF_IDRt(rt),
        .IF_IDuseRs(urs), .IF_IDuseRt(urt), .mem_wait(mw),
        .ID_EXzero(zx[3]), .IF_IDhold(hx[3]), .sel(sx[3]), .pipe_freeze(fx[3]),
`ifdef LOAD_USE_PERF_EN
        .perf_stalls(ps[3]), .perf_freezes(pf[3]),
`endif
        .stall_run(sr3));

    // {ID_EXzero, IF_IDhold, sel, pipe_freeze}
    function automatic logic [3:0] ctl(input int i);
        return {zx[i], hx[i], sx[i], fx[i]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic mr_, input logic [4:0] ert_, input logic [4:0] rs_,
                       input logic [4:0] rt_, input logic urs_, input logic urt_, input logic mw_);
        mr = mr_; ert = ert_; rs = rs_; rt = rt_; urs = urs_; urt = urt_; mw = mw_;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        // reset with hazard-looking inputs: outputs must stay low
        rst = 1'b1;
        drv(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("rst_ctl0", ctl(0), 4'b0000);
        chk("rst_ctl3", ctl(3), 4'b0000);
        chk("rst_sr0", sr0, 0);
        repeat (2) tick();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ctl0", ctl(0), 4'b0000);
        idle(4);

        // LOAD_LAT=1 single bubble
        drv(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("l1_c0_ctl", ctl(0), 4'b1110);
        chk("l1_c0_sr", sr0, 0);
        tick();
        drv(1'b0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("l1_c1_ctl", ctl(0), 4'b0000);
        chk("l1_c1_sr", sr0, 1);
        tick();
        chk("l1_c2_sr", sr0, 0);
        idle(4);

        // LOAD_LAT=3, consumer reads rt
        drv(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0); #1;
        chk("l3_c0_ctl", ctl(3), 4'b1110);
        chk("l3_c0_sr", sr3, 0);
        tick();
        drv(1'b0, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0); #1;
        chk("l3_c1_ctl", ctl(3), 4'b1110);
        chk("l3_c1_sr", sr3, 1);
        chk("l3_c1_lat1_ctl", ctl(0), 4'b0000);
        chk("l3_c1_lat2_ctl", ctl(2), 4'b1110);
        tick();
        chk("l3_c2_ctl", ctl(3), 4'b1110);
        chk("l3_c2_sr", sr3, 2);
        chk("l3_c2_lat2_ctl", ctl(2), 4'b0000);
        tick();
        chk("l3_c3_ctl", ctl(3), 4'b0000);
        chk("l3_c3_sr", sr3, 3);
        tick();
        chk("l3_c4_sr", sr3, 0);
        idle(4);

        // register matches but is not read
        drv(1'b1, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0); #1;
        chk("nouse_ctl0", ctl(0), 4'b0000);
        chk("nouse_ctl1", ctl(1), 4'b0000);
        chk("nouse_ctl3", ctl(3), 4'b0000);
        tick();
        idle(4);

        // register 0 with and without exemption
        drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("r0_exempt_ctl", ctl(0), 4'b0000);
        chk("r0_noexempt_ctl", ctl(1), 4'b1110);
        tick();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("r0_noexempt_c1_ctl", ctl(1), 4'b0000);
        chk("r0_noexempt_c1_sr", srz, 1);
        chk("r0_exempt_c1_sr", sr0, 0);
        idle(4);

        // mem_wait during LOAD_LAT=2 stall
        drv(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("mw_c0_ctl", ctl(2), 4'b1110);
        tick();
        drv(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("mw_c1_ctl", ctl(2), 4'b1110);
        chk("mw_c1_sr", sr2, 1);
        drv(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1); #1;
        chk("mw_c1w_ctl", ctl(2), 4'b0111);
        chk("mw_c1w_lat1_ctl", ctl(0), 4'b0111);
        tick();
        chk("mw_c2_ctl", ctl(2), 4'b0111);
        chk("mw_c2_sr", sr2, 1);
        drv(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("mw_c3_ctl", ctl(2), 4'b1110);
        chk("mw_c3_sr", sr2, 1);
        tick();
        chk("mw_c4_ctl", ctl(2), 4'b0000);
        chk("mw_c4_sr", sr2, 2);
        tick();
        chk("mw_c5_sr", sr2, 0);
        idle(4);

        // stall_run saturation (CNT_W=2 build) vs. wide counter
        drv(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        chk("sat_srz", srz, 3);
        chk("sat_sr0", sr0, 5);
        chk("sat_ctl0", ctl(0), 4'b1110);
        idle(4);

        // reset mid-stall, LOAD_LAT=3
        drv(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("rs_c0_ctl", ctl(3), 4'b1110);
        tick();
        drv(1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("rs_c1_ctl", ctl(3), 4'b1110);
        chk("rs_c1_sr", sr3, 1);
        rst = 1'b1; #1;
        chk("rs_async_ctl", ctl(3), 4'b0000);
        chk("rs_async_sr", sr3, 0);
        tick();
        rst = 1'b0; #1;
        chk("rs_rel_ctl", ctl(3), 4'b0000);
        tick();
        chk("rs_rel1_ctl", ctl(3), 4'b0000);
        chk("rs_rel1_sr", sr3, 0);
        drv(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("rs_newload_ctl", ctl(3), 4'b1110);
        tick();
        idle(4);

        // back-to-back loads tracked independently, LOAD_LAT=3
        drv(1'b1, 5'd4, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("b2b_c0_ctl", ctl(3), 4'b0000);
        tick();
        drv(1'b1, 5'd6, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("b2b_c1_ctl", ctl(3), 4'b1110);
        tick();
        drv(1'b0, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("b2b_c2_rs6_ctl", ctl(3), 4'b1110);
        drv(1'b0, 5'd6, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("b2b_c2_rs4_ctl", ctl(3), 4'b1110);
        drv(1'b0, 5'd6, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        chk("b2b_c2_rs7_ctl", ctl(3), 4'b0000);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
